// File: rtl/stream_rr_merge_pkg.sv
// Shared types and helpers for the stream_rr_merge block:
// FSM state encoding, token width and EOT bit position.
package stream_rr_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A token is the payload plus one end-of-transfer flag on top.
    function automatic int tok_w(input int data_w);
        return data_w + 1;
    endfunction

    // EOT sits directly above the payload.
    function automatic int eot_idx(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/stream_rr_merge_rr_grant.sv
// Round-robin grant: picks the first eligible request at or after ptr
// (wrapping modulo N) and returns it one-hot plus as an index.
module rr_grant #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  elig,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && elig[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_rr_merge.sv
// stream_rr_merge: merges N_IN token streams into one, one token per grant,
// round-robin across inputs, through a one-entry output buffer.
// Build option STREAM_RR_MERGE_EOT_MERGE_EN: absorb every input EOT and emit
// a single EOT (FLUSH state) once all inputs have closed. Without it, input
// EOT tokens are forwarded like data and FLUSH is never entered.
module stream_rr_merge
    import stream_rr_merge_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int DATA_W = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_idle,
    output logic                         ap_ready,
    input  logic [N_IN*(DATA_W+1)-1:0]   in_s_dout,
    input  logic [N_IN-1:0]              in_s_empty_n,
    output logic [N_IN-1:0]              in_s_read,
    output logic [DATA_W:0]              out_s_din,
    input  logic                         out_s_full_n,
    output logic                         out_s_write
);

    localparam int TW  = tok_w(DATA_W);
    localparam int EOT = eot_idx(DATA_W);
    localparam int PW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [TW-1:0] FLUSH_TOK = {1'b1, {DATA_W{1'b0}}};

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [N_IN-1:0] closed;
    logic            buf_vld;
    logic [TW-1:0]   buf_data;

    logic [N_IN-1:0] elig, gnt;
    logic [PW-1:0]   gnt_idx, ptr_nxt;
    logic            any, drain, load, rd_eot;
    logic [TW-1:0]   rd_tok;

    // Reads only while running and while the output side accepts: with
    // full_n high the buffer is either empty or drains this same cycle.
    assign elig = (state == ST_RUN && out_s_full_n) ? (in_s_empty_n & ~closed) : '0;

    rr_grant #(.N(N_IN), .PW(PW)) u_grant (
        .ptr     (rr_ptr),
        .elig    (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign in_s_read = gnt;
    assign rd_tok    = in_s_dout[int'(gnt_idx)*TW +: TW];
    assign rd_eot    = rd_tok[EOT];
    assign ptr_nxt   = (gnt_idx == PW'(N_IN-1)) ? '0 : gnt_idx + 1'b1;
    assign drain     = buf_vld & out_s_full_n;

`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
    assign load = any & ~rd_eot;
`else
    assign load = any;
`endif

    assign out_s_write = drain | ((state == ST_FLUSH) & out_s_full_n);
    assign out_s_din   = (state == ST_FLUSH) ? FLUSH_TOK : buf_data;

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next state and block-level handshake outputs.
    always_comb begin
        state_nxt = state;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_idle   = 1'b0;
        case (state)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if ((&closed) && !buf_vld) begin
`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
                    state_nxt = ST_FLUSH;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_FLUSH: begin
                if (out_s_full_n) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration pointer, closed flags and the one-entry output buffer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr   <= '0;
            closed   <= '0;
            buf_vld  <= 1'b0;
            buf_data <= '0;
        end else begin
            if (any) begin
                rr_ptr <= ptr_nxt;
                if (rd_eot) closed <= closed | gnt;
            end
            if (state == ST_DONE) closed <= '0;
            if (load) begin
                buf_vld  <= 1'b1;
                buf_data <= rd_tok;
            end else if (drain) begin
                buf_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed bench for stream_rr_merge (N_IN=2, DATA_W=8). Input FIFOs and the
// output sink are modelled with queues; expected token orders are written
// out by hand per scenario.
module tb_stream_rr_merge;

    localparam int N_IN = 2;
    localparam int DW   = 8;
    localparam int TW   = DW + 1;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ap_start = 1'b0;
    logic               ap_done, ap_idle, ap_ready;
    logic [N_IN*TW-1:0] in_s_dout;
    logic [N_IN-1:0]    in_s_empty_n;
    logic [N_IN-1:0]    in_s_read;
    logic [TW-1:0]      out_s_din;
    logic               out_s_full_n = 1'b1;
    logic               out_s_write;

    int n_run  = 0;
    int n_fail = 0;

    logic [TW-1:0] q0[$], q1[$], exp_q[$], log_q[$];
    int            lcyc[$];
    int            cyc = 0, ndone = 0;
    bit            toggle_fn = 0, stall_chk = 0, t2_arm = 0;

    logic [N_IN-1:0] rd_q;
    logic            wr_q, done_q, fn_q, bv_q;
    logic [TW-1:0]   wd_q;

    stream_rr_merge #(.N_IN(N_IN), .DATA_W(DW)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .in_s_dout    (in_s_dout),
        .in_s_empty_n (in_s_empty_n),
        .in_s_read    (in_s_read),
        .out_s_din    (out_s_din),
        .out_s_full_n (out_s_full_n),
        .out_s_write  (out_s_write)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [TW-1:0] tk(input logic eot, input logic [DW-1:0] d);
        return {eot, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        in_s_empty_n[0]     = (q0.size() > 0);
        in_s_empty_n[1]     = (q1.size() > 0);
        in_s_dout[0 +: TW]  = (q0.size() > 0) ? q0[0] : '0;
        in_s_dout[TW +: TW] = (q1.size() > 0) ? q1[0] : '0;
    endtask

    // Capture what transferred at this edge (pre-edge values).
    always @(posedge ap_clk) begin
        rd_q   = in_s_read;
        wr_q   = out_s_write;
        wd_q   = out_s_din;
        done_q = ap_done;
        fn_q   = out_s_full_n;
        bv_q   = dut.buf_vld;
    end

    // Apply the transfers to the FIFO models, then drive the next cycle.
    always @(negedge ap_clk) begin
        logic [TW-1:0] t;
        if (stall_chk && !fn_q) begin
            check("stall_rd", 32'(rd_q), 0);
            if (bv_q) check("stall_din", 32'(out_s_din), 32'(wd_q));
        end
        if (rd_q != '0) check("rd_onehot", 32'($countones(rd_q)), 1);
        if (rd_q[0]) begin
            check("rd0_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (rd_q[1]) begin
            check("rd1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() > 0) begin
                t = q1.pop_front();
                if (t2_arm && t[DW]) begin
                    q0.push_back(tk(0, 8'hA0));
                    q0.push_back(tk(0, 8'hA1));
                    q0.push_back(tk(1, 8'hAE));
                    t2_arm = 0;
                end
            end
        end
        if (wr_q) begin
            log_q.push_back(wd_q);
            lcyc.push_back(cyc);
        end
        if (done_q) ndone++;
        rd_q   = '0;
        wr_q   = 1'b0;
        done_q = 1'b0;
        if (toggle_fn) out_s_full_n = ~out_s_full_n;
        drive();
        cyc++;
    end

    task automatic load_t1();
        q0.delete(); q1.delete(); exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(tk(0, 8'(8'hA0 + k)));
            q1.push_back(tk(0, 8'(8'hB0 + k)));
        end
        q0.push_back(tk(1, 8'hAE));
        q1.push_back(tk(1, 8'hBE));
        exp_q = '{tk(0,8'hA0), tk(0,8'hB0), tk(0,8'hA1), tk(0,8'hB1), tk(0,8'hA2), tk(0,8'hB2)};
`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
        exp_q.push_back(tk(1, 8'h00));
`else
        exp_q.push_back(tk(1, 8'hAE));
        exp_q.push_back(tk(1, 8'hBE));
`endif
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_tok%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    task automatic consec(input string tag, input int from, input int n);
        for (int i = from; i < from + n - 1 && i + 1 < lcyc.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), 32'(lcyc[i+1] - lcyc[i]), 1);
    endtask

    task automatic run(input string tag, input int budget);
        int d0;
        bit seen;
        log_q.delete(); lcyc.delete();
        @(negedge ap_clk); ap_start = 1'b1;
        @(negedge ap_clk); ap_start = 1'b0;
        d0 = ndone; seen = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge ap_clk);
            if (ndone != d0) begin seen = 1; break; end
        end
        check({tag, "_done"}, 32'(seen), 1);
        repeat (2) @(negedge ap_clk);
        check({tag, "_ndone"}, 32'(ndone - d0), 1);
        compare_log(tag);
    endtask

    initial begin
        int  d0;
        bit  seen;
        drive();
        #12;
        check("rst_idle",  32'(ap_idle), 1);
        check("rst_done",  32'(ap_done), 0);
        check("rst_ready", 32'(ap_ready), 0);
        check("rst_write", 32'(out_s_write), 0);
        check("rst_read",  32'(in_s_read), 0);
        check("rst_din",   32'(out_s_din), 0);
        @(negedge ap_clk); ap_rst_n = 1'b1;

        // Two full inputs, free-flowing output.
        load_t1();
        run("t1", 100);
        consec("t1", 0, 6);

        // Output backpressure toggling every cycle.
        load_t1();
        toggle_fn = 1; stall_chk = 1;
        run("t3", 200);
        toggle_fn = 0; stall_chk = 0; out_s_full_n = 1'b1;

        // Reset mid-run with a token sitting in the buffer.
        load_t1();
        @(negedge ap_clk); ap_start = 1'b1;
        @(negedge ap_clk); ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("t4_bv_pre", 32'(dut.buf_vld), 1);
        d0 = ndone;
        #2 ap_rst_n = 1'b0;
        #1;
        check("t4_write", 32'(out_s_write), 0);
        check("t4_idle",  32'(ap_idle), 1);
        check("t4_read",  32'(in_s_read), 0);
        check("t4_din",   32'(out_s_din), 0);
        @(negedge ap_clk);
        check("t4_write2", 32'(out_s_write), 0);
        check("t4_idle2",  32'(ap_idle), 1);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        check("t4_nodone", 32'(ndone - d0), 0);
        load_t1();
        run("t4", 100);

        // ap_start held high across the whole run.
        load_t1();
        log_q.delete(); lcyc.delete();
        d0 = ndone; seen = 0;
        @(negedge ap_clk); ap_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge ap_clk);
            if (ap_done) begin ap_start = 1'b0; seen = 1; break; end
        end
        check("t5_done", 32'(seen), 1);
        repeat (3) @(negedge ap_clk);
        check("t5_idle",  32'(ap_idle), 1);
        check("t5_ndone", 32'(ndone - d0), 1);
        compare_log("t5");

        // Input 0 closes at once (with a token behind its EOT); input 1 streams.
        q0.delete(); q1.delete(); exp_q.delete();
        q0.push_back(tk(1, 8'hAE));
        q0.push_back(tk(0, 8'h55));
        for (int k = 0; k < 4; k++) q1.push_back(tk(0, 8'(8'hB0 + k)));
        q1.push_back(tk(1, 8'hBE));
`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
        exp_q = '{tk(0,8'hB0), tk(0,8'hB1), tk(0,8'hB2), tk(0,8'hB3), tk(1,8'h00)};
`else
        exp_q = '{tk(1,8'hAE), tk(0,8'hB0), tk(0,8'hB1), tk(0,8'hB2), tk(0,8'hB3), tk(1,8'hBE)};
`endif
        run("t6", 100);
`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
        consec("t6", 0, 4);
`else
        consec("t6", 1, 4);
`endif
        check("t6_q0_left", 32'(q0.size()), 1);
        q0.delete();

        // Only input 1 has data; input 0 fills once input 1 closes.
        q0.delete(); q1.delete(); exp_q.delete();
        for (int k = 0; k < 5; k++) q1.push_back(tk(0, 8'(8'hB0 + k)));
        q1.push_back(tk(1, 8'hBE));
        t2_arm = 1;
        exp_q = '{tk(0,8'hB0), tk(0,8'hB1), tk(0,8'hB2), tk(0,8'hB3), tk(0,8'hB4)};
`ifdef STREAM_RR_MERGE_EOT_MERGE_EN
        exp_q.push_back(tk(0, 8'hA0));
        exp_q.push_back(tk(0, 8'hA1));
        exp_q.push_back(tk(1, 8'h00));
`else
        exp_q.push_back(tk(1, 8'hBE));
        exp_q.push_back(tk(0, 8'hA0));
        exp_q.push_back(tk(0, 8'hA1));
        exp_q.push_back(tk(1, 8'hAE));
`endif
        run("t2", 150);
        consec("t2", 0, 5);
        check("t2_armed", 32'(t2_arm), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
